// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the CPU/loader memory arbiter.
package cpu_mem_arb_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int READ_LATENCY = 2;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_L = 1'b1
    } port_e;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the loader has been denied;
// o_at_limit tells the arbiter to force a loader grant.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 4'(LIMIT))) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_cnt == 4'(LIMIT));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port RAM arbiter: CPU has priority, loader is forced through after
// STARVE_LIMIT denied cycles. Define ARB_STATS_EN to add grant statistics.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       c_grant_cnt,
    output logic [15:0]       l_grant_cnt,
    output logic [7:0]        starve_force_cnt
`endif
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic              w_at_limit;
    logic              w_l_force;
    logic              w_gnt_c;
    logic              w_gnt_l;
    logic              w_any;
    port_e             w_sel;
    cmd_t              w_cmd;
    logic              w_c_rvalid;
    logic              w_l_rvalid;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_tag_vld  [READ_LATENCY];
    port_e             r_tag_port [READ_LATENCY];
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_l_rdata;

    // Arbitration: a starved loader overrides the CPU's fixed priority.
    always_comb begin
        w_l_force = l_req && w_at_limit;
        w_gnt_l   = !reset && (w_l_force || (!c_req && l_req));
        w_gnt_c   = !reset && c_req && !w_l_force;
        w_any     = w_gnt_c || w_gnt_l;
        w_sel     = w_gnt_l ? PORT_L : PORT_C;
        w_cmd.we    = w_gnt_l ? l_we    : c_we;
        w_cmd.addr  = w_gnt_l ? l_addr  : c_addr;
        w_cmd.wdata = w_gnt_l ? l_wdata : c_wdata;
    end

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_gnt_l || !l_req),
        .i_inc      (l_req && !w_gnt_l),
        .o_at_limit (w_at_limit)
    );

    // Issue stage plus read-tag pipeline; tag slot 0 lines up with mem_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_c_rdata   <= '0;
            r_l_rdata   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_vld[i]  <= 1'b0;
                r_tag_port[i] <= PORT_C;
            end
        end else begin
            r_mem_en <= w_any;
            r_mem_we <= w_any && w_cmd.we;
            if (w_any) begin
                r_mem_addr  <= w_cmd.addr;
                r_mem_wdata <= w_cmd.wdata;
            end
            r_tag_vld[0]  <= w_any && !w_cmd.we;
            r_tag_port[0] <= w_sel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
            if (w_c_rvalid) r_c_rdata <= mem_rdata;
            if (w_l_rvalid) r_l_rdata <= mem_rdata;
        end
    end

    // Response stage: the RAM's registered output goes to the tagged owner,
    // the other port keeps showing its last read word.
    assign w_c_rvalid = !reset && r_tag_vld[READ_LATENCY-1] && (r_tag_port[READ_LATENCY-1] == PORT_C);
    assign w_l_rvalid = !reset && r_tag_vld[READ_LATENCY-1] && (r_tag_port[READ_LATENCY-1] == PORT_L);

    assign c_gnt     = w_gnt_c;
    assign l_gnt     = w_gnt_l;
    assign c_rvalid  = w_c_rvalid;
    assign l_rvalid  = w_l_rvalid;
    assign c_rdata   = w_c_rvalid ? mem_rdata : r_c_rdata;
    assign l_rdata   = w_l_rvalid ? mem_rdata : r_l_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef ARB_STATS_EN
    logic [15:0] r_c_grant_cnt;
    logic [15:0] r_l_grant_cnt;
    logic [7:0]  r_force_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_grant_cnt <= '0;
            r_l_grant_cnt <= '0;
            r_force_cnt   <= '0;
        end else begin
            if (w_gnt_c && (r_c_grant_cnt != '1)) r_c_grant_cnt <= r_c_grant_cnt + 16'd1;
            if (w_gnt_l && (r_l_grant_cnt != '1)) r_l_grant_cnt <= r_l_grant_cnt + 16'd1;
            if (w_gnt_l && w_l_force && (r_force_cnt != '1)) r_force_cnt <= r_force_cnt + 8'd1;
        end
    end

    assign c_grant_cnt      = r_c_grant_cnt;
    assign l_grant_cnt      = r_l_grant_cnt;
    assign starve_force_cnt = r_force_cnt;
`endif

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the CPU's single-port synchronous data/instruction RAM between two requesters: the CPU core (port C) and a program loader/debug port (port L).
- Fixed priority to the CPU, with a starvation guard that forces a loader grant after a bounded wait.
- Registers the memory command and routes read data back to the requester that issued the read.
- Sits between the CPU instance and the RAM at top level.

Parameters:
- ADDR_W, 8, address width in words.
- DATA_W, 16, data word width.
- STARVE_LIMIT, 4, consecutive denied cycles of a pending loader request before the loader is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  CPU request; held with its command until c_gnt.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU grant pulse; combinational, same cycle as the accepted request.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  DATA_W  CPU read data.
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader command; same rules as the CPU command.
- l_gnt  out  1  loader grant pulse.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_W  loader read data.
- mem_en  out  1  registered RAM enable.
- mem_we  out  1  registered RAM write enable.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values (while reset=1 and on the edge after):
  - all gnt, rvalid, mem_en and mem_we = 0;
  - addr/data outputs = 0;
  - starve_cnt = 0;
  - in-flight read tags cleared.
- Reset mid-operation drops any pending rvalid. No response is ever produced for a command accepted before reset.
- Arbitration (combinational, every cycle):
  - if l_req && starve_cnt == STARVE_LIMIT: grant L;
  - else if c_req: grant C;
  - else if l_req: grant L;
  - else no grant.
- At most one gnt is high per cycle. Back-to-back grants every cycle are allowed; throughput is 1 access/cycle.
- starve_cnt:
  - increments when l_req && !l_gnt, saturating at STARVE_LIMIT;
  - clears to 0 on l_gnt or when l_req=0.
- Issue stage: on a grant in cycle N, mem_en/mem_we/mem_addr/mem_wdata are loaded from the winner and appear in N+1.
  - No grant: mem_en=0, mem_we=0; addr/data hold their previous values.
- Response stage: a read granted in N gets mem_rdata in N+2.
  - The winner's rvalid is pulsed high for 1 cycle in N+2, with rdata = mem_rdata registered. Read latency from gnt is 2 cycles.
  - A 2-deep tag pipeline (valid + port id) tracks which port gets the data.
  - The non-owner's rdata holds its last value.
- Writes produce no rvalid. A write is complete at N+1 from the arbiter's viewpoint.
- Requester protocol: req/we/addr/wdata must stay stable until gnt. After gnt, the requester may present a new request in the very next cycle.
- Simultaneous c_req and l_req with starve_cnt < STARVE_LIMIT: C wins and starve_cnt increments.
- Read-after-write to the same address from different ports: ordering follows grant order. No forwarding.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - adds outputs c_grant_cnt and l_grant_cnt (16 bits each, saturating) and starve_force_cnt (8 bits, saturating; counts forced loader grants);
  - all three reset to 0.
- When undefined: these ports and their registers do not exist, and arbitration behaviour is identical.

Decomposition:
- Package cpu_mem_arb_pkg holds:
  - typedef enum logic {PORT_C, PORT_L} port_e;
  - typedef struct packed {logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} mem_cmd_t, with default widths as package localparams;
  - localparam READ_LATENCY = 2.
- One sub-module: arb_starve_ctr, the saturating starvation counter with clear/increment inputs and an at_limit output.

Test Plan:
- Reset then CPU read: reset for 2 cycles, c_req read at addr 0x10 (RAM[0x10]=0x1234) -> c_gnt same cycle, mem_en=1 with mem_addr=0x10 next cycle, c_rvalid=1 with c_rdata=0x1234 two cycles after gnt, l_rvalid stays 0.
- Loader write then CPU read: l_req write 0x20←0xBEEF with no c_req -> l_gnt, mem_we=1 in N+1; c_req read 0x20 in N+1 -> c_rdata=0xBEEF.
- Starvation: c_req and l_req held continuously, STARVE_LIMIT=4 -> c_gnt for 4 cycles, l_gnt on the 5th, then CPU resumes. Pattern repeats with period 5.
- Back-to-back reads alternating ports (C@1, L@2, C@3) -> three rvalid pulses in consecutive cycles, each on the correct port with correct data, never both rvalid high together.
- Reset mid-read: assert reset the cycle after c_gnt -> no c_rvalid ever appears; all outputs 0 the cycle after reset.
- ARB_STATS_EN build: run the starvation scenario for 10 cycles -> c_grant_cnt=8, l_grant_cnt=2, starve_force_cnt=2.
